// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: PS/2 set-2 frame receiver presenting each keycode on `key`
// for HOLD_CYCLES clocks, then returning to KP_INVALID (8'h00).
module ps2_keycode_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int HOLD_CYCLES    = 1024,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key,
    output logic       key_valid,
    output logic       parity_err,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic [FW-1:0]          flt_cnt_q;
    logic                   filt_q, filt_prev_q;
    logic                   sclk, din, fall;

    state_t        state_q, state_d;
    logic [7:0]    sr_q, sr_d;
    logic [2:0]    bit_q, bit_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [7:0]    key_d;
    logic          timeout, stop_fall, par_ok, good, perr_d, ferr_d;

    assign sclk = clk_sync_q[SYNC_STAGES-1];
    assign din  = data_sync_q[SYNC_STAGES-1];
    assign fall = filt_prev_q & ~filt_q;

    // Bus idles high, so conditioning flops preset to 1 to avoid a false fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            flt_cnt_q   <= '0;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            filt_prev_q <= filt_q;
            if (sclk == filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_q    <= sclk;
                flt_cnt_q <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        par_d   = par_q;
        timeout = state_q != IDLE && !fall && to_q == TW'(TIMEOUT_CYCLES - 1);
        to_d    = (state_q == IDLE || fall || timeout) ? '0 : to_q + 1'b1;
        if (timeout) begin
            state_d = IDLE;
            sr_d    = '0;
            bit_d   = '0;
            par_d   = 1'b0;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    state_d = din ? IDLE : DATA;
                    bit_d   = '0;
                end
                DATA: begin
                    sr_d    = {din, sr_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = din;
                    state_d = STOP;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Stop-bit errors take precedence over parity errors.
    always_comb begin
        stop_fall = state_q == STOP && fall;
        par_ok    = ^{sr_q, par_q};
        good      = stop_fall && din && par_ok;
        perr_d    = stop_fall && din && !par_ok;
        ferr_d    = timeout || (fall && state_q == IDLE && din) || (stop_fall && !din);
        key_d     = good ? sr_q : (key != 8'h00 && hold_q == '0) ? 8'h00 : key;
        hold_d    = good ? HW'(HOLD_CYCLES - 1) : (key != 8'h00 && hold_q != '0) ? hold_q - 1'b1 : hold_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key        <= 8'h00;
            hold_q     <= '0;
            key_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            key        <= key_d;
            hold_q     <= hold_d;
            key_valid  <= good;
            parity_err <= perr_d;
            frame_err  <= ferr_d;
        end
    end
endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb_ps2_keycode_rx: directed bench driving PS/2 frames and checking presented codes,
// hold timing and status pulses.
module tb_ps2_keycode_rx;
    logic       clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] key;
    logic       key_valid, parity_err, frame_err;

    int nchk = 0, nerr = 0;
    int now = 0, nvalid = 0, nperr = 0, nferr = 0, nclr = 0, excl_bad = 0;
    int t_valid = 0, t_clear = 0, t73 = 0, c0 = 0;
    logic [7:0] last_key = 8'h00, prev_key = 8'h00;

    ps2_keycode_rx #(.SYNC_STAGES(2), .FILTER_LEN(8), .HOLD_CYCLES(256), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key(key), .key_valid(key_valid), .parity_err(parity_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        now++;
        if (key_valid) begin
            nvalid++;
            last_key = key;
            t_valid  = now;
        end
        if (parity_err) nperr++;
        if (frame_err) nferr++;
        if (prev_key != 8'h00 && key == 8'h00) begin
            nclr++;
            t_clear = now;
        end
        prev_key = key;
        if (int'(key_valid) + int'(parity_err) + int'(frame_err) > 1) excl_bad++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Keyboard drives data while ps2_clk is high; g adds sub-filter glitches in both phases.
    task automatic send(input logic [7:0] b, input bit badp = 0, input bit stop = 1,
                        input int nbits = 11, input int half = 20, input bit g = 0);
        logic [10:0] bits;
        bits = {stop, (~^b) ^ badp, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            tick(5);
            ps2_clk = 1'b0;
            if (g) begin
                tick(12); ps2_clk = 1'b1; tick(7); ps2_clk = 1'b0; tick(half - 19);
            end else tick(half);
            ps2_clk = 1'b1;
            if (g) begin
                tick(12); ps2_clk = 1'b0; tick(7); ps2_clk = 1'b1; tick(half - 24);
            end else tick(half - 5);
        end
        ps2_data = 1'b1;
    endtask

    initial begin
        tick(5);
        chk("reset_key", key, 8'h00);
        chk("reset_pulses", {key_valid, parity_err, frame_err}, 0);
        reset = 1'b0;
        tick(5);

        send(8'h70);
        tick(20);
        chk("t1_nvalid", nvalid, 1);
        chk("t1_key", key, 8'h70);
        chk("t1_errs", nperr + nferr, 0);
        tick(300);
        chk("t1_cleared", key, 8'h00);
        chk("t1_hold", t_clear - t_valid, 256);

        send(8'hF0);
        tick(20);
        chk("t2_f0", last_key, 8'hF0);
        tick(560);
        chk("t2_gap", key, 8'h00);
        chk("t2_f0_hold", t_clear - t_valid, 256);
        send(8'h70);
        tick(20);
        chk("t2_70", last_key, 8'h70);
        chk("t2_nvalid", nvalid, 3);
        tick(300);
        chk("t2_70_hold", t_clear - t_valid, 256);

        send(8'h7C, 1);
        tick(20);
        chk("t3_perr", nperr, 1);
        chk("t3_no_valid", nvalid, 3);
        chk("t3_key", key, 8'h00);
        send(8'h69);
        tick(20);
        chk("t3_69", last_key, 8'h69);
        tick(300);

        send(8'h72, 0, 0);
        tick(20);
        chk("t4_stop_ferr", nferr, 1);
        chk("t4_stop_key", key, 8'h00);
        chk("t4_stop_nvalid", nvalid, 4);
        send(8'h7A, 0, 1, 5);
        tick(1100);
        chk("t4_timeout_ferr", nferr, 2);
        send(8'h7A);
        tick(20);
        chk("t4_7a", last_key, 8'h7A);
        chk("t4_nvalid", nvalid, 5);
        tick(300);

        send(8'h6B, 0, 1, 11, 30, 1);
        tick(20);
        chk("t5_6b", last_key, 8'h6B);
        chk("t5_errs", nperr * 16 + nferr, 16 + 2);
        tick(300);

        c0 = nclr;
        send(8'h73, 0, 1, 11, 10);
        chk("t6_73", last_key, 8'h73);
        t73 = t_valid;
        send(8'h74, 0, 1, 11, 10);
        tick(20);
        chk("t6_74", last_key, 8'h74);
        chk("t6_no_gap", nclr, c0);
        chk("t6_overlap", int'(t_valid - t73 < 256), 1);
        tick(300);
        chk("t6_hold", t_clear - t_valid, 256);

        send(8'h6B);
        tick(20);
        send(8'h5A, 0, 1, 4);
        #2 reset = 1'b1;
        #1;
        chk("t7_async_key", key, 8'h00);
        chk("t7_async_pulses", {key_valid, parity_err, frame_err}, 0);
        c0 = nferr + nvalid;
        tick(3);
        reset = 1'b0;
        tick(1100);
        chk("t7_idle", nferr + nvalid, c0);
        send(8'h5A);
        tick(20);
        chk("t7_5a", last_key, 8'h5A);

        chk("exclusive", excl_bad, 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
